pc_fetch_unit: RTL and testbench

//   Fetch/next-PC stage of the single-cycle MIPS core. Holds the PC, drives the

---
 rtl/pc_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Fetch / next-PC stage of a single-cycle MIPS core.
//                Holds the PC, drives the instruction-memory word address and
//                splits the fetched word into decoder fields. Resolves the next
//                PC from the decoder's branch/jump outputs, runs the syscall
//                halt/resume FSM and keeps run statistics.
//  Ports       : clk, rst_n (sync, active low), go (resume pulse)
//                instr (IMEM read data), Beq/Bne/BLTZ, JMP/JAL/JR, syscall,
//                alu_zero, rs_data, v0_data
//                pc, pc_plus4, imem_addr, OpCode/funct/rs/rt/rd/shamt/imm16,
//                halted, cycle_cnt, jump_cnt, br_taken_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 10,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_CODE = 32'd10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [31:0]        instr,
    input  logic               Beq,
    input  logic               Bne,
    input  logic               BLTZ,
    input  logic               JMP,
    input  logic               JAL,
    input  logic               JR,
    input  logic               syscall,
    input  logic               alu_zero,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        v0_data,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [5:0]         OpCode,
    output logic [5:0]         funct,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [15:0]        imm16,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   jump_cnt,
    output logic [CNT_W-1:0]   br_taken_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_q,        state_d;
    logic [31:0]        pc_q,           pc_d;
    logic               halted_q,       halted_d;
    logic [CNT_W-1:0]   cycle_cnt_q,    cycle_cnt_d;
    logic [CNT_W-1:0]   jump_cnt_q,     jump_cnt_d;
    logic [CNT_W-1:0]   br_taken_cnt_q, br_taken_cnt_d;

    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_br_off;
    logic [31:0]        w_br_tgt;
    logic [31:0]        w_j_tgt;
    logic               w_is_jump;
    logic               w_br_taken;
    logic               w_halt_req;

    // ------------------------------------------------------------------------
    // Target and condition resolution
    // ------------------------------------------------------------------------
    always_comb begin
        w_pc_plus4 = pc_q + 32'd4;
        w_br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
        w_br_tgt   = w_pc_plus4 + w_br_off;
        w_j_tgt    = {w_pc_plus4[31:28], instr[25:0], 2'b00};
        w_is_jump  = JMP | JAL | JR;
        w_br_taken = (Beq & alu_zero) | (Bne & ~alu_zero) | (BLTZ & rs_data[31]);
        w_halt_req = syscall && (v0_data == HALT_CODE);
    end

    // ------------------------------------------------------------------------
    // Next-state: FSM, PC and statistics
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        halted_d       = halted_q;
        cycle_cnt_d    = cycle_cnt_q;
        jump_cnt_d     = jump_cnt_q;
        br_taken_cnt_d = br_taken_cnt_q;

        case (state_q)
            ST_RUN: begin
                // Every RUN cycle counts, the halting syscall cycle included.
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                if (w_halt_req) begin
                    // PC stays on the syscall so resume can step past it.
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    if (JR) begin
                        pc_d = rs_data;
                    end else if (JMP | JAL) begin
                        pc_d = w_j_tgt;
                    end else if (w_br_taken) begin
                        pc_d = w_br_tgt;
                    end else begin
                        pc_d = w_pc_plus4;
                    end
                    // A jump overrides any branch flag raised alongside it.
                    if (w_is_jump) begin
                        jump_cnt_d = jump_cnt_q + CNT_W'(1);
                    end else if (w_br_taken) begin
                        br_taken_cnt_d = br_taken_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (go) begin
                    state_d  = ST_RUN;
                    halted_d = 1'b0;
                    pc_d     = w_pc_plus4;
                end
            end
            default: begin
                state_d  = ST_RUN;
                halted_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_PC;
            halted_q       <= 1'b0;
            cycle_cnt_q    <= '0;
            jump_cnt_q     <= '0;
            br_taken_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            halted_q       <= halted_d;
            cycle_cnt_q    <= cycle_cnt_d;
            jump_cnt_q     <= jump_cnt_d;
            br_taken_cnt_q <= br_taken_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pc           = pc_q;
    assign pc_plus4     = w_pc_plus4;
    assign imem_addr    = pc_q[IMEM_AW+1:2];
    assign OpCode       = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign shamt        = instr[10:6];
    assign funct        = instr[5:0];
    assign imm16        = instr[15:0];
    assign halted       = halted_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign jump_cnt     = jump_cnt_q;
    assign br_taken_cnt = br_taken_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Scoreboard bench for pc_fetch_unit. Stimulus drives inputs
//                on the falling edge and queues the hand-computed state
//                expected after the next rising edge; a monitor pops and
//                compares one entry per rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic [31:0] instr;
    logic        Beq, Bne, BLTZ, JMP, JAL, JR, syscall, alu_zero;
    logic [31:0] rs_data;
    logic [31:0] v0_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [9:0]  imem_addr;
    logic [5:0]  OpCode;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic        halted;
    logic [31:0] cycle_cnt, jump_cnt, br_taken_cnt;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .instr        (instr),
        .Beq          (Beq),
        .Bne          (Bne),
        .BLTZ         (BLTZ),
        .JMP          (JMP),
        .JAL          (JAL),
        .JR           (JR),
        .syscall      (syscall),
        .alu_zero     (alu_zero),
        .rs_data      (rs_data),
        .v0_data      (v0_data),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .imem_addr    (imem_addr),
        .OpCode       (OpCode),
        .funct        (funct),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .imm16        (imm16),
        .halted       (halted),
        .cycle_cnt    (cycle_cnt),
        .jump_cnt     (jump_cnt),
        .br_taken_cnt (br_taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic [31:0] cyc;
        logic [31:0] jmp;
        logic [31:0] br;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_cyc = 0;
    logic [31:0] exp_jmp = 0;
    logic [31:0] exp_br  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one queued expectation per rising edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc",           pc,             e.pc);
            chk("pc_plus4",     pc_plus4,       e.pc + 32'd4);
            chk("halted",       {31'd0, halted}, {31'd0, e.halted});
            chk("cycle_cnt",    cycle_cnt,      e.cyc);
            chk("jump_cnt",     jump_cnt,       e.jmp);
            chk("br_taken_cnt", br_taken_cnt,   e.br);
        end
    end

    task automatic clr();
        Beq = 0; Bne = 0; BLTZ = 0; JMP = 0; JAL = 0; JR = 0;
        syscall = 0; alu_zero = 0; go = 0;
        instr = 32'h0; rs_data = 32'h0; v0_data = 32'h0;
    endtask

    // Queue the state expected after the coming rising edge, then advance.
    task automatic tick(input logic [31:0] e_pc, input logic e_halt,
                        input int dc, input int dj, input int db);
        exp_t e;
        exp_cyc = exp_cyc + 32'(dc);
        exp_jmp = exp_jmp + 32'(dj);
        exp_br  = exp_br  + 32'(db);
        e.pc = e_pc; e.halted = e_halt;
        e.cyc = exp_cyc; e.jmp = exp_jmp; e.br = exp_br;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        @(negedge clk);

        // ---- Reset then three NOPs
        rst_n = 1'b0; tick(32'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick(32'h4, 0, 1, 0, 0);
        tick(32'h8, 0, 1, 0, 0);
        tick(32'hC, 0, 1, 0, 0);

        // ---- Field slicing (combinational)
        instr = 32'h8D2A_F7C5;
        #1;
        chk("OpCode",    {26'd0, OpCode}, 32'h23);
        chk("rs",        {27'd0, rs},     32'd9);
        chk("rt",        {27'd0, rt},     32'd10);
        chk("rd",        {27'd0, rd},     32'd30);
        chk("shamt",     {27'd0, shamt},  32'd31);
        chk("funct",     {26'd0, funct},  32'd5);
        chk("imm16",     {16'd0, imm16},  32'h0000_F7C5);
        chk("imem_addr", {22'd0, imem_addr}, 32'd3);
        instr = 32'h0;

        // ---- Beq backward taken / not taken
        tick(32'h10, 0, 1, 0, 0);
        Beq = 1; alu_zero = 1; instr = 32'h1000_FFFE;
        tick(32'h0C, 0, 1, 0, 1);
        clr();
        tick(32'h10, 0, 1, 0, 0);
        Beq = 1; alu_zero = 0; instr = 32'h1000_FFFE;
        tick(32'h14, 0, 1, 0, 0);

        // ---- Jumps
        clr(); JR = 1; rs_data = 32'h3000_0040;
        tick(32'h3000_0040, 0, 1, 1, 0);
        clr(); JAL = 1; instr = 32'h0C00_0040;
        tick(32'h3000_0100, 0, 1, 1, 0);
        clr(); JR = 1; JMP = 1; rs_data = 32'h200; instr = 32'h0800_0040;
        tick(32'h200, 0, 1, 1, 0);
        clr(); JMP = 1; Beq = 1; alu_zero = 1; instr = 32'h0800_0008;
        tick(32'h20, 0, 1, 1, 0);

        // ---- BLTZ, Bne, wrap, unaligned JR
        clr(); BLTZ = 1; rs_data = 32'h8000_0000; instr = 32'h0400_0004;
        tick(32'h34, 0, 1, 0, 1);
        clr(); JR = 1; rs_data = 32'h20;
        tick(32'h20, 0, 1, 1, 0);
        clr(); BLTZ = 1; rs_data = 32'h1; instr = 32'h0400_0004;
        tick(32'h24, 0, 1, 0, 0);
        clr(); Bne = 1; alu_zero = 0; instr = 32'h1400_0001;
        tick(32'h2C, 0, 1, 0, 1);
        clr(); JR = 1; rs_data = 32'hFFFF_FFF0;
        tick(32'hFFFF_FFF0, 0, 1, 1, 0);
        clr(); Beq = 1; alu_zero = 1; instr = 32'h1000_0004;
        tick(32'h0000_0004, 0, 1, 0, 1);
        clr(); JR = 1; rs_data = 32'h53;
        tick(32'h53, 0, 1, 1, 0);
        clr(); JR = 1; rs_data = 32'h50;
        tick(32'h50, 0, 1, 1, 0);

        // ---- Halt, hold 5 cycles with jump decode present, resume
        clr(); syscall = 1; v0_data = 32'd10;
        tick(32'h50, 1, 1, 0, 0);
        JR = 1; rs_data = 32'h999;
        for (int i = 0; i < 5; i++) tick(32'h50, 1, 0, 0, 0);
        go = 1;
        tick(32'h54, 0, 0, 0, 0);
        clr(); syscall = 1; v0_data = 32'd1;
        tick(32'h58, 0, 1, 0, 0);
        clr(); go = 1;
        tick(32'h5C, 0, 1, 0, 0);

        // ---- Reset while halted
        clr(); syscall = 1; v0_data = 32'd10;
        tick(32'h5C, 1, 1, 0, 0);
        tick(32'h5C, 1, 0, 0, 0);
        rst_n = 1'b0;
        exp_cyc = 0; exp_jmp = 0; exp_br = 0;
        tick(32'h0, 0, 0, 0, 0);
        rst_n = 1'b1; clr();
        tick(32'h4, 0, 1, 0, 0);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
